// File: rtl/fsm_bist_ctrl.sv
// fsm_bist_ctrl
//
// Built-in self-test sequencer for the JTAG-controlled Moore FSM (fsm_mur).
// A start request from the TAP (while test mode is high) clears the FSM,
// drives it with LFSR pseudo-random stimulus for PAT_CNT cycles, compacts
// every FSM state into a 16-bit MISR and compares the result with a golden
// signature.
//
// Ports:
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   tmode_i        in   test mode from the TAP; must stay high for a run
//   bist_start_i   in   single-cycle start request
//   state_i[3:0]   in   FSM state_o, compacted into the MISR
//   sig_o[3:0]     out  stimulus to FSM sig_in (LFSR low nibble in RUN)
//   tmode_clk_en_o out  FSM clock enable
//   start_bist_o   out  FSM synchronous clear at run start
//   rst_state_o    out  FSM synchronous clear on abort
//   busy_o         out  run in progress
//   done_o         out  result valid (held until the next start)
//   pass_o         out  signature matched GOLDEN_SIG, valid with done_o
//   signature_o    out  final MISR value
//   dbg_state[2:0] out  current sequencer state, for debug and checkers
//
// Start/done handshake: bist_start_i is a one-cycle request accepted only
// when the sequencer is not busy (IDLE or DONE) and tmode_i is high; there
// is no back-pressure, a request that is not accepted is simply dropped.
// done_o then stays high, with pass_o and signature_o stable, until the
// next accepted request or a reset.

module fsm_bist_ctrl #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PAT_CNT    = 255,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tmode_i,
    input  logic        bist_start_i,
    input  logic [3:0]  state_i,
    output logic [3:0]  sig_o,
    output logic        tmode_clk_en_o,
    output logic        start_bist_o,
    output logic        rst_state_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] signature_o,
    output logic [2:0]  dbg_state
);

    // Parameter legality, caught at elaboration
    if (PAT_CNT == 0) begin : g_bad_pat_cnt
        $error("fsm_bist_ctrl: PAT_CNT must be at least 1");
    end
    if (64'(PAT_CNT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_big_pat_cnt
        $error("fsm_bist_ctrl: PAT_CNT does not fit in CNT_W bits");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("fsm_bist_ctrl: LFSR_SEED must be nonzero");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_FLUSH   = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5,
        S_ABORT   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LAST_PAT = CNT_W'(PAT_CNT - 1);

    state_t           state;
    state_t           state_next;
    logic [15:0]      lfsr;
    logic [15:0]      misr;
    logic [CNT_W-1:0] pat_cnt;
    logic [15:0]      sig_q;
    logic             pass_q;

    logic             start_req;
    logic [15:0]      lfsr_next;
    logic [15:0]      misr_next;

    assign start_req = bist_start_i && tmode_i;
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign misr_next = {misr[14:0], misr[15] ^ misr[13] ^ misr[12] ^ misr[10]}
                       ^ {12'b0, state_i};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A tmode_i fall wins over every progress transition
    // of the active phases (INIT, RUN, FLUSH).
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_req) state_next = S_INIT;
            end
            S_INIT: begin
                state_next = tmode_i ? S_RUN : S_ABORT;
            end
            S_RUN: begin
                if (!tmode_i)               state_next = S_ABORT;
                else if (pat_cnt == LAST_PAT) state_next = S_FLUSH;
            end
            S_FLUSH: begin
                state_next = tmode_i ? S_COMPARE : S_ABORT;
            end
            S_COMPARE: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                if (start_req) state_next = S_INIT;
            end
            S_ABORT: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: everything comes from the state or held registers.
    // ------------------------------------------------------------------
    always_comb begin
        sig_o          = 4'h0;
        tmode_clk_en_o = 1'b0;
        start_bist_o   = 1'b0;
        rst_state_o    = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        case (state)
            S_INIT: begin
                start_bist_o   = 1'b1;
                tmode_clk_en_o = 1'b1;
                busy_o         = 1'b1;
            end
            S_RUN: begin
                sig_o          = lfsr[3:0];
                tmode_clk_en_o = 1'b1;
                busy_o         = 1'b1;
            end
            S_FLUSH: begin
                // FSM frozen so its last state can be absorbed
                busy_o = 1'b1;
            end
            S_COMPARE: begin
                busy_o = 1'b1;
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            S_ABORT: begin
                rst_state_o    = 1'b1;
                tmode_clk_en_o = 1'b1;
                busy_o         = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pass_o      = pass_q;
    assign signature_o = sig_q;
    assign dbg_state   = state;

    // ------------------------------------------------------------------
    // Datapath: stimulus LFSR, compaction MISR, pattern counter, results
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr    <= 16'h0000;
            misr    <= 16'h0000;
            pat_cnt <= '0;
            sig_q   <= 16'h0000;
            pass_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // pass_o must not look valid while a new run is pending
                    if (start_req) pass_q <= 1'b0;
                end
                S_INIT: begin
                    lfsr    <= LFSR_SEED;
                    misr    <= 16'h0000;
                    pat_cnt <= '0;
                end
                S_RUN: begin
                    misr    <= misr_next;
                    lfsr    <= lfsr_next;
                    pat_cnt <= pat_cnt + CNT_W'(1);
                end
                S_FLUSH: begin
                    // Final sample: state after the last pattern
                    misr <= misr_next;
                end
                S_COMPARE: begin
                    sig_q  <= misr;
                    pass_q <= (misr == GOLDEN_SIG);
                end
                S_ABORT: begin
                    pass_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_bist_ctrl.sv
// Testbench for fsm_bist_ctrl.
// Three instances: a and b share stimulus (PAT_CNT=4) and differ only in the
// golden signature, c runs the full 255-pattern sequence. The downstream FSM
// is stood in for by directed and random state_i samples; the reference
// model predicts stimulus and signature from those samples.
`timescale 1ns/1ps

module tb_fsm_bist_ctrl;

    localparam int          P_AB   = 4;
    localparam int          P_C    = 255;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam logic [15:0] GOLD_A = 16'h001D;
    localparam logic [15:0] GOLD_B = 16'h001C;
    localparam logic [15:0] GOLD_C = 16'h0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        tmode_ab = 1'b0, start_ab = 1'b0;
    logic [3:0]  st_ab = 4'h0;
    logic        tmode_c = 1'b0, start_c = 1'b0;
    logic [3:0]  st_c = 4'h0;

    logic [3:0]  sig_a, sig_b, sig_c;
    logic        clk_en_a, clk_en_b, clk_en_c;
    logic        start_bist_a, start_bist_b, start_bist_c;
    logic        rst_state_a, rst_state_b, rst_state_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        pass_a, pass_b, pass_c;
    logic [15:0] signature_a, signature_b, signature_c;
    logic [2:0]  dbg_a, dbg_b, dbg_c;

    fsm_bist_ctrl #(.CNT_W(16), .PAT_CNT(P_AB), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .tmode_i(tmode_ab), .bist_start_i(start_ab), .state_i(st_ab),
        .sig_o(sig_a), .tmode_clk_en_o(clk_en_a), .start_bist_o(start_bist_a),
        .rst_state_o(rst_state_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
        .signature_o(signature_a), .dbg_state(dbg_a)
    );

    fsm_bist_ctrl #(.CNT_W(16), .PAT_CNT(P_AB), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .tmode_i(tmode_ab), .bist_start_i(start_ab), .state_i(st_ab),
        .sig_o(sig_b), .tmode_clk_en_o(clk_en_b), .start_bist_o(start_bist_b),
        .rst_state_o(rst_state_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
        .signature_o(signature_b), .dbg_state(dbg_b)
    );

    fsm_bist_ctrl #(.CNT_W(16), .PAT_CNT(P_C), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD_C)) dut_c (
        .clk(clk), .rst_n(rst_n), .tmode_i(tmode_c), .bist_start_i(start_c), .state_i(st_c),
        .sig_o(sig_c), .tmode_clk_en_o(clk_en_c), .start_bist_o(start_bist_c),
        .rst_state_o(rst_state_c), .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c),
        .signature_o(signature_c), .dbg_state(dbg_c)
    );

    // ---------------- scoreboard ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic [3:0]  smp_q[$];        // state_i samples for the next run
    logic [15:0] exp_q[$];        // expected signature of each completed a/b run
    logic [15:0] prev_sig = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Shift left, feeding back the parity of taps 15,13,12,10.
    function automatic logic [15:0] step16(input logic [15:0] x);
        return {x[14:0], ^(x & 16'hB400)};
    endfunction

    function automatic logic [15:0] misr_fold(input logic [3:0] s[$]);
        logic [15:0] m = 16'h0000;
        foreach (s[i]) m = step16(m) ^ {12'h000, s[i]};
        return m;
    endfunction

    // ---------------- driver tasks ----------------
    // Advance one cycle; outputs are sampled 1 ns after the edge. The two
    // PAT_CNT=4 instances must stay cycle-identical apart from pass_o.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("ab_lockstep",
            32'({sig_b, clk_en_b, start_bist_b, rst_state_b, busy_b, done_b, dbg_b}),
            32'({sig_a, clk_en_a, start_bist_a, rst_state_a, busy_a, done_a, dbg_a}));
    endtask

    task automatic fill_random();
        smp_q.delete();
        smp_q.push_back(4'h0);    // FSM was cleared in INIT
        for (int i = 0; i < P_AB; i++) smp_q.push_back(4'($urandom_range(0, 15)));
    endtask

    // Full run on a/b using smp_q. poke=1 pulses bist_start_i in RUN cycle 2.
    task automatic run_ab(input bit poke);
        logic [15:0] lf;
        logic [15:0] exp_sig;
        int t0;
        exp_sig = misr_fold(smp_q);
        exp_q.push_back(exp_sig);
        tmode_ab = 1'b1;
        start_ab = 1'b1;
        t0 = cyc;                 // cycle in which the request is presented
        tick();
        start_ab = 1'b0;
        chk("init_start_bist", 32'(start_bist_a), 32'd1);
        chk("init_clk_en", 32'(clk_en_a), 32'd1);
        chk("init_busy", 32'(busy_a), 32'd1);
        chk("init_sig", 32'(sig_a), 32'd0);
        chk("init_done_clr", 32'(done_a), 32'd0);
        chk("init_pass_clr", 32'(pass_a), 32'd0);
        chk("init_sig_held", 32'(signature_a), 32'(prev_sig));
        lf = SEED;
        for (int k = 0; k < P_AB; k++) begin
            tick();
            start_ab = 1'b0;
            chk("run_sig", 32'(sig_a), 32'(lf[3:0]));
            chk("run_clk_en", 32'(clk_en_a), 32'd1);
            chk("run_start_bist", 32'(start_bist_a), 32'd0);
            st_ab = smp_q[k];
            start_ab = poke && (k == 1);
            lf = step16(lf);
        end
        tick();
        start_ab = 1'b0;
        chk("flush_clk_en", 32'(clk_en_a), 32'd0);
        chk("flush_sig", 32'(sig_a), 32'd0);
        chk("flush_busy", 32'(busy_a), 32'd1);
        st_ab = smp_q[P_AB];
        tick();
        chk("compare_busy", 32'(busy_a), 32'd1);
        chk("compare_done", 32'(done_a), 32'd0);
        tick();
        chk("done_a", 32'(done_a), 32'd1);
        chk("done_b", 32'(done_b), 32'd1);
        chk("done_busy", 32'(busy_a), 32'd0);
        chk("done_latency", 32'(cyc - t0), 32'(P_AB + 4));
        chk("sig_a", 32'(signature_a), 32'(exp_q[$]));
        chk("sig_b", 32'(signature_b), 32'(exp_q[$]));
        chk("pass_a", 32'(pass_a), 32'(exp_q[$] == GOLD_A));
        chk("pass_b", 32'(pass_b), 32'(exp_q[$] == GOLD_B));
        prev_sig = exp_sig;
        tick();
        chk("done_sticky", 32'(done_a), 32'd1);
        chk("sig_held", 32'(signature_a), 32'(prev_sig));
    endtask

    // Full 255-pattern run on instance c with random FSM samples.
    task automatic run_c();
        logic [15:0] lf;
        logic [3:0]  v;
        int t0;
        int n;
        smp_q.delete();
        tmode_c = 1'b1;
        start_c = 1'b1;
        t0 = cyc;
        tick();
        start_c = 1'b0;
        chk("c_init_start_bist", 32'(start_bist_c), 32'd1);
        chk("c_init_busy", 32'(busy_c), 32'd1);
        lf = SEED;
        for (int k = 0; k < P_C; k++) begin
            tick();
            chk("c_run_sig", 32'(sig_c), 32'(lf[3:0]));
            chk("c_run_clk_en", 32'(clk_en_c), 32'd1);
            v = (k == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            st_c = v;
            smp_q.push_back(v);
            lf = step16(lf);
        end
        tick();
        chk("c_flush_clk_en", 32'(clk_en_c), 32'd0);
        v = 4'($urandom_range(0, 15));
        st_c = v;
        smp_q.push_back(v);
        n = 0;
        while (done_c !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("c_done", 32'(done_c), 32'd1);
        chk("c_done_latency", 32'(cyc - t0), 32'(P_C + 4));
        chk("c_signature", 32'(signature_c), 32'(misr_fold(smp_q)));
        chk("c_pass", 32'(pass_c), 32'(misr_fold(smp_q) == GOLD_C));
        chk("c_busy", 32'(busy_c), 32'd0);
        chk("c_rst_state", 32'(rst_state_c), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_pass", 32'(pass_a), 32'd0);
        chk("rst_signature", 32'(signature_a), 32'd0);
        chk("rst_outs", 32'({sig_a, clk_en_a, start_bist_a, rst_state_a}), 32'd0);
        chk("rst_c_outs", 32'({sig_c, clk_en_c, start_bist_c, rst_state_c, busy_c, done_c, pass_c}), 32'd0);
        chk("rst_c_signature", 32'(signature_c), 32'd0);
        chk("rst_c_dbg", 32'(dbg_c), 32'(dbg_a));
        rst_n = 1'b1;
        tick();

        // Directed passing/failing run with the known FSM trace
        smp_q = '{4'h0, 4'h2, 4'h0, 4'h0, 4'hD};
        run_ab(1'b0);
        chk("directed_sig_const", 32'(signature_a), 32'h001D);

        // Restart from DONE with identical samples: identical signature
        run_ab(1'b0);

        // Start pulse during RUN is ignored
        fill_random();
        run_ab(1'b1);

        // Abort: tmode_i drops in the 2nd RUN cycle
        tmode_ab = 1'b1;
        start_ab = 1'b1;
        tick();                   // INIT
        start_ab = 1'b0;
        tick();                   // RUN 1
        st_ab = 4'h0;
        tick();                   // RUN 2
        st_ab = 4'h5;
        tmode_ab = 1'b0;
        tick();                   // ABORT
        chk("abort_rst_state", 32'(rst_state_a), 32'd1);
        chk("abort_clk_en", 32'(clk_en_a), 32'd1);
        chk("abort_busy", 32'(busy_a), 32'd1);
        chk("abort_start_bist", 32'(start_bist_a), 32'd0);
        chk("abort_done", 32'(done_a), 32'd0);
        chk("abort_pass", 32'(pass_a), 32'd0);
        chk("abort_sig_held", 32'(signature_a), 32'(prev_sig));
        tick();                   // IDLE
        chk("post_abort_busy", 32'(busy_a), 32'd0);
        chk("post_abort_rst_state", 32'(rst_state_a), 32'd0);
        chk("post_abort_clk_en", 32'(clk_en_a), 32'd0);
        chk("post_abort_done", 32'(done_a), 32'd0);

        // Start with tmode_i low is ignored
        start_ab = 1'b1;
        tick();
        start_ab = 1'b0;
        chk("tmode0_busy", 32'(busy_a), 32'd0);
        chk("tmode0_start_bist", 32'(start_bist_a), 32'd0);
        tick();
        chk("tmode0_busy2", 32'(busy_a), 32'd0);

        // Random runs
        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_ab(1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a run
        fill_random();
        tmode_ab = 1'b1;
        start_ab = 1'b1;
        tick();
        start_ab = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_outs", 32'({sig_a, clk_en_a, start_bist_a, rst_state_a, done_a, pass_a}), 32'd0);
        chk("arst_signature", 32'(signature_a), 32'd0);
        prev_sig = 16'h0000;
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_rel_busy", 32'(busy_a), 32'd0);
        chk("arst_rel_done", 32'(done_a), 32'd0);
        chk("arst_rel_rst_state", 32'(rst_state_a), 32'd0);

        // Long run
        tmode_ab = 1'b0;
        run_c();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
